// File: rtl/bcd_mod_counter_if.sv
// Control and data bundle for one bcd_mod_counter stage.
// The master drives the requests. The slave (the counter) returns the count, tc and load_err.
interface bcd_mod_counter_if;
  logic       clr;
  logic       load;
  logic [7:0] data_in;
  logic       en;
  logic       up;
  logic [7:0] data_out;
  logic       tc;
  logic       load_err;

  modport master (
    output clr, load, data_in, en, up,
    input  data_out, tc, load_err
  );

  modport slave (
    input  clr, load, data_in, en, up,
    output data_out, tc, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter over MIN_VAL..MAX_VAL with clear, checked load and cascade tc.
// Define BCD_MOD_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module bcd_mod_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 23
) (
  input logic             clk,
  input logic             rst_n,
  bcd_mod_counter_if.slave bus
);

  if (MAX_VAL > 99 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_param_check
    $error("bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL <= 99");
  end

  localparam logic [7:0] MIN_BCD = 8'(((MIN_VAL / 10) << 4) | (MIN_VAL % 10));
  localparam logic [7:0] MAX_BCD = 8'(((MAX_VAL / 10) << 4) | (MAX_VAL % 10));

  logic [7:0] r_count;
  logic       r_load_err;

  logic [3:0] w_units;
  logic [3:0] w_tens;
  logic       w_legal;
  logic       w_at_max;
  logic       w_at_min;
  logic       w_load_ok;
  logic [7:0] w_step;

  assign w_units  = r_count[3:0];
  assign w_tens   = r_count[7:4];
  assign w_at_max = (r_count == MAX_BCD);
  assign w_at_min = (r_count == MIN_BCD);

  // With both nibbles in 0..9, a BCD byte orders exactly like its decimal value.
  assign w_legal  = (w_units <= 4'd9) && (w_tens <= 4'd9) &&
                    (r_count >= MIN_BCD) && (r_count <= MAX_BCD);

  assign w_load_ok = (bus.data_in[3:0] <= 4'd9) && (bus.data_in[7:4] <= 4'd9) &&
                     (bus.data_in >= MIN_BCD) && (bus.data_in <= MAX_BCD);

  always_comb begin
    // NOTE: assigning a default first means no path leaves w_step unassigned, so no latch.
    w_step = r_count;
    if (!w_legal) begin
      w_step = MIN_BCD;
    end else if (bus.up) begin
      if (w_at_max) begin
`ifdef BCD_MOD_COUNTER_SAT_EN
        w_step = r_count;
`else
        w_step = MIN_BCD;
`endif
      end else if (w_units == 4'd9) begin
        w_step = {4'(w_tens + 4'd1), 4'd0};
      end else begin
        w_step = {w_tens, 4'(w_units + 4'd1)};
      end
    end else begin
      if (w_at_min) begin
`ifdef BCD_MOD_COUNTER_SAT_EN
        w_step = r_count;
`else
        w_step = MAX_BCD;
`endif
      end else if (w_units == 4'd0) begin
        w_step = {4'(w_tens - 4'd1), 4'd9};
      end else begin
        w_step = {w_tens, 4'(w_units - 4'd1)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      r_count    <= MIN_BCD;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      if (bus.clr) begin
        r_count <= MIN_BCD;
      end else if (bus.load) begin
        if (w_load_ok) r_count <= bus.data_in;
        r_load_err <= ~w_load_ok;
      end else if (bus.en) begin
        r_count <= w_step;
      end
    end
  end

  // tc fires in the same cycle as the wrapping step, so it can drive the next stage's en directly.
  assign bus.tc       = bus.en & ~bus.clr & ~bus.load &
                        ((bus.up & w_at_max) | (~bus.up & w_at_min));
  assign bus.data_out = r_count;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: four instances (0..23, 1..12, and a cascaded 0..59 pair).
// The reference model works in plain decimal integers.
module tb_bcd_mod_counter;

`ifdef BCD_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int MINS [4] = '{0, 1, 0, 0};
  localparam int MAXS [4] = '{23, 12, 59, 59};

  logic clk;
  logic rst_n;

  logic       s_clr  [4];
  logic       s_load [4];
  logic [7:0] s_data [4];
  logic       s_en   [4];
  logic       s_up   [4];
  logic [7:0] o_data [4];
  logic       o_tc   [4];
  logic       o_err  [4];

  int m_val [4];
  bit m_err [4];
  int n_vec;
  int n_err;

  bcd_mod_counter_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_wire
    assign bus[g].clr     = s_clr[g];
    assign bus[g].load    = s_load[g];
    assign bus[g].data_in = s_data[g];
    assign bus[g].up      = s_up[g];
    if (g == 3) begin : g_cascade
      assign bus[g].en = bus[2].tc;
    end else begin : g_direct
      assign bus[g].en = s_en[g];
    end
    assign o_data[g] = bus[g].data_out;
    assign o_tc[g]   = bus[g].tc;
    assign o_err[g]  = bus[g].load_err;
  end

  bcd_mod_counter u_hours (.clk(clk), .rst_n(rst_n), .bus(bus[0].slave));
  bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12)) u_hours12 (.clk(clk), .rst_n(rst_n), .bus(bus[1].slave));
  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_sec (.clk(clk), .rst_n(rst_n), .bus(bus[2].slave));
  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59)) u_min (.clk(clk), .rst_n(rst_n), .bus(bus[3].slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit din_ok(int mn, int mx, logic [7:0] d);
    int t = int'(d[7:4]);
    int u = int'(d[3:0]);
    return (t <= 9) && (u <= 9) && (t * 10 + u >= mn) && (t * 10 + u <= mx);
  endfunction

  function automatic int next_val(int mn, int mx, int v, bit clr, bit load, bit en, bit up,
                                  logic [7:0] d);
    if (clr) return mn;
    if (load) return din_ok(mn, mx, d) ? int'(d[7:4]) * 10 + int'(d[3:0]) : v;
    if (!en) return v;
    if (up) return (v == mx) ? (SAT ? v : mn) : v + 1;
    return (v == mn) ? (SAT ? v : mx) : v - 1;
  endfunction

  function automatic bit tc_of(int mn, int mx, int v, bit clr, bit load, bit en, bit up);
    return en && !clr && !load && ((up && v == mx) || (!up && v == mn));
  endfunction

  task automatic check(string tag, logic [7:0] observed, logic [7:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      s_clr[i] = 1'b0; s_load[i] = 1'b0; s_data[i] = 8'h00; s_en[i] = 1'b0; s_up[i] = 1'b1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = MINS[i];
      m_err[i] = 1'b0;
    end
  endtask

  task automatic check_reset_values(string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), o_data[i], to_bcd(MINS[i]));
      check($sformatf("%s_err[%0d]", tag, i), 8'(o_err[i]), 8'h00);
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  // Checks tc, advances one clock, then checks the registered outputs.
  task automatic step();
    bit e_tc [4];
    bit en_eff;
    int nv [4];
    bit ne [4];
    #1;
    for (int i = 0; i < 4; i++) begin
      en_eff = (i == 3) ? e_tc[2] : s_en[i];
      e_tc[i] = tc_of(MINS[i], MAXS[i], m_val[i], s_clr[i], s_load[i], en_eff, s_up[i]);
      check($sformatf("tc[%0d]", i), 8'(o_tc[i]), 8'(e_tc[i]));
      nv[i] = next_val(MINS[i], MAXS[i], m_val[i], s_clr[i], s_load[i], en_eff, s_up[i], s_data[i]);
      ne[i] = s_load[i] && !s_clr[i] && !din_ok(MINS[i], MAXS[i], s_data[i]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = nv[i];
      m_err[i] = ne[i];
      check($sformatf("data[%0d]", i), o_data[i], to_bcd(m_val[i]));
      check($sformatf("load_err[%0d]", i), 8'(o_err[i]), 8'(m_err[i]));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    // Hours 0..23 counting up through the wrap, 1..12 counting down.
    s_en[0] = 1'b1; s_up[0] = 1'b1;
    s_up[1] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      s_en[1] = (k < 4);
      step();
    end
    idle();

    // Load: one valid value, then out-of-range and non-BCD values.
    s_load[0] = 1'b1; s_data[0] = 8'h15;
    step();
    s_data[0] = 8'h24; step();
    s_load[0] = 1'b0;  step();
    s_load[0] = 1'b1; s_data[0] = 8'h1A; step();
    s_data[0] = 8'hA0; step();
    idle(); step();

    // Priority: clr beats load beats en.
    s_load[0] = 1'b1; s_data[0] = 8'h23; step();
    s_clr[0] = 1'b1; s_load[0] = 1'b1; s_data[0] = 8'h07; s_en[0] = 1'b1;
    step();
    s_clr[0] = 1'b0;
    step();
    idle();

    // Cascade: both 0..59 stages at 59 roll over to 00 on the same edge.
    s_load[2] = 1'b1; s_load[3] = 1'b1; s_data[2] = 8'h59; s_data[3] = 8'h59;
    step();
    idle();
    s_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    s_up[2] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    idle();

    // Saturation or wrap at both range ends with en held.
    s_load[0] = 1'b1; s_data[0] = 8'h22; step();
    s_load[0] = 1'b0; s_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    s_up[0] = 1'b0;
    step();
    idle();

    // Randomised traffic on all stages.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        s_clr[i]  = ($urandom_range(0, 15) == 0);
        s_load[i] = ($urandom_range(0, 7) == 0);
        s_data[i] = ($urandom_range(0, 1) == 0) ? to_bcd($urandom_range(0, 99)) : 8'($urandom);
        s_en[i]   = ($urandom_range(0, 3) != 0);
        s_up[i]   = ($urandom_range(0, 1) == 0);
      end
      step();
    end

    // Asynchronous reset in the middle of counting.
    for (int i = 0; i < 4; i++) begin
      s_clr[i] = 1'b0; s_load[i] = 1'b0; s_en[i] = 1'b1; s_up[i] = 1'b1;
    end
    s_load[2] = 1'b1; s_data[2] = 8'h59; s_load[3] = 1'b1; s_data[3] = 8'h41;
    step();
    s_load[2] = 1'b0; s_load[3] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(posedge clk);
    #1;
    check_reset_values("held_reset");
    idle();
    model_reset();
    rst_n = 1'b1;
    s_en[0] = 1'b1; s_en[2] = 1'b1;
    for (int k = 0; k < 3; k++) step();
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
